// File: rtl/regfile_scan_ctrl_if.sv
// Bus bundle between the register-file scan controller and its environment.
// REGFILE_SCAN_CKSUM_EN adds the running XOR checksum output.
interface regfile_scan_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              start;
    logic              mode;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_rdata;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_we;
    logic [DATA_W-1:0] dump_data;
    logic [ADDR_W-1:0] dump_idx;
    logic              dump_valid;
    logic              dump_ready;
    logic [DATA_W-1:0] load_data;
    logic              load_valid;
    logic              load_ready;
`ifdef REGFILE_SCAN_CKSUM_EN
    logic [DATA_W-1:0] cksum;
`endif

    modport master (
`ifdef REGFILE_SCAN_CKSUM_EN
        output cksum,
`endif
        input  start, mode, rf_rdata, dump_ready, load_data, load_valid,
        output busy, done, rf_addr, rf_wdata, rf_we,
        output dump_data, dump_idx, dump_valid, load_ready
    );

    modport slave (
`ifdef REGFILE_SCAN_CKSUM_EN
        input  cksum,
`endif
        output start, mode, rf_rdata, dump_ready, load_data, load_valid,
        input  busy, done, rf_addr, rf_wdata, rf_we,
        input  dump_data, dump_idx, dump_valid, load_ready
    );
endinterface

// File: rtl/regfile_scan_ctrl.sv
// Sequential register-file dump (x0..x31 out) / load (x1..x31 in) controller.
// Optional macro REGFILE_SCAN_CKSUM_EN adds an XOR checksum of all transferred words.
module regfile_scan_ctrl #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_scan_ctrl_if.master  bus
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_DUMP_RD   = 3'd1;
    localparam logic [2:0] S_DUMP_HOLD = 3'd2;
    localparam logic [2:0] S_LOAD      = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] dump_data_q, dump_data_d;
    logic [ADDR_W-1:0] dump_idx_q, dump_idx_d;
    logic              dump_valid_q, dump_valid_d;
    logic [DATA_W-1:0] cksum_q, cksum_d;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        dump_data_d  = dump_data_q;
        dump_idx_d   = dump_idx_q;
        dump_valid_d = dump_valid_q;
        cksum_d      = cksum_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    cksum_d = '0;
                    if (bus.mode) begin
                        idx_d   = ADDR_W'(1);
                        state_d = S_LOAD;
                    end else begin
                        idx_d   = '0;
                        state_d = S_DUMP_RD;
                    end
                end
            end
            S_DUMP_RD: begin
                dump_data_d  = bus.rf_rdata;
                dump_idx_d   = idx_q;
                dump_valid_d = 1'b1;
                state_d      = S_DUMP_HOLD;
            end
            S_DUMP_HOLD: begin
                if (bus.dump_ready) begin
                    dump_valid_d = 1'b0;
                    cksum_d      = cksum_q ^ dump_data_q;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = S_DUMP_RD;
                    end
                end
            end
            S_LOAD: begin
                if (bus.load_valid) begin
                    cksum_d = cksum_q ^ bus.load_data;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            dump_data_q  <= '0;
            dump_idx_q   <= '0;
            dump_valid_q <= 1'b0;
            cksum_q      <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            dump_data_q  <= dump_data_d;
            dump_idx_q   <= dump_idx_d;
            dump_valid_q <= dump_valid_d;
            cksum_q      <= cksum_d;
        end
    end

    // The write strobe is gated by rst so a reset landing mid-LOAD cannot commit a word.
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.load_ready = (state_q == S_LOAD);
    assign bus.rf_addr    = (state_q == S_DUMP_RD || state_q == S_DUMP_HOLD ||
                             state_q == S_LOAD) ? idx_q : '0;
    assign bus.rf_wdata   = (state_q == S_LOAD) ? bus.load_data : '0;
    assign bus.rf_we      = rst && (state_q == S_LOAD) && bus.load_valid;
    assign bus.dump_data  = dump_data_q;
    assign bus.dump_idx   = dump_idx_q;
    assign bus.dump_valid = dump_valid_q;

`ifdef REGFILE_SCAN_CKSUM_EN
    assign bus.cksum = cksum_q;
`else
    logic unused_cksum;
    assign unused_cksum = ^cksum_q;
`endif
endmodule

// File: tb/tb_regfile_scan_ctrl.sv
// Scoreboard bench for regfile_scan_ctrl: bench-side register file, reference
// register array, expected-beat queues and a negedge monitor.
`timescale 1ns/1ps
module tb_regfile_scan_ctrl;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int EW       = ADDR_W + DATA_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_scan_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    regfile_scan_ctrl #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register file the controller talks to
    logic [DATA_W-1:0] rf_mem [NUM_REGS];
    logic              rf_clear;
    always @(posedge clk) begin
        if (rf_clear) begin
            for (int i = 0; i < NUM_REGS; i++) rf_mem[i] <= '0;
        end else if (bus.rf_we) begin
            rf_mem[bus.rf_addr] <= bus.rf_wdata;
        end
    end
    assign bus.rf_rdata = rf_mem[bus.rf_addr];

    // Reference state and scoreboard
    logic [DATA_W-1:0] ref_regs [NUM_REGS];
    logic [EW-1:0]     exp_dump_q [$];
    logic [EW-1:0]     exp_wr_q   [$];
    logic [DATA_W-1:0] model_cks;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int busy_cnt    = 0;
    int ready_mode  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: evaluates the values that the next rising edge will commit
    logic              hold_prev;
    logic [DATA_W-1:0] prev_data;
    logic [ADDR_W-1:0] prev_idx;
    initial begin
        logic [EW-1:0] e;
        hold_prev = 1'b0;
        prev_data = '0;
        prev_idx  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (bus.busy) busy_cnt++;
                if (bus.done) done_cnt++;
                if (hold_prev && bus.dump_valid) begin
                    chk("dump_hold_data", bus.dump_data, prev_data);
                    chk("dump_hold_idx", bus.dump_idx, prev_idx);
                end
                if (bus.dump_valid && bus.dump_ready) begin
                    if (exp_dump_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL dump_extra: got idx %0d data 0x%0h with no beat expected",
                                 bus.dump_idx, bus.dump_data);
                    end else begin
                        e = exp_dump_q.pop_front();
                        chk("dump_idx", bus.dump_idx, e[DATA_W +: ADDR_W]);
                        chk("dump_data", bus.dump_data, e[DATA_W-1:0]);
                    end
                end
                if (bus.rf_we) begin
                    if (exp_wr_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL write_extra: got addr %0d data 0x%0h with no write expected",
                                 bus.rf_addr, bus.rf_wdata);
                    end else begin
                        e = exp_wr_q.pop_front();
                        chk("wr_addr", bus.rf_addr, e[DATA_W +: ADDR_W]);
                        chk("wr_data", bus.rf_wdata, e[DATA_W-1:0]);
                    end
                end
                hold_prev = bus.dump_valid && !bus.dump_ready;
                prev_data = bus.dump_data;
                prev_idx  = bus.dump_idx;
            end else begin
                chk("we_during_reset", bus.rf_we, 0);
                hold_prev = 1'b0;
            end
        end
    end

    // Consumer-side ready pattern: 0 tied high, 1 one cycle in three, 2 random
    initial begin
        int c;
        c = 0;
        bus.dump_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.dump_ready = 1'b1;
                1: begin bus.dump_ready = (c % 3 == 0); c++; end
                default: bus.dump_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_dump_valid"}, bus.dump_valid, 0);
        chk({tag, "_dump_data"}, bus.dump_data, 0);
        chk({tag, "_dump_idx"}, bus.dump_idx, 0);
        chk({tag, "_load_ready"}, bus.load_ready, 0);
        chk({tag, "_rf_addr"}, bus.rf_addr, 0);
        chk({tag, "_rf_wdata"}, bus.rf_wdata, 0);
        chk({tag, "_rf_we"}, bus.rf_we, 0);
`ifdef REGFILE_SCAN_CKSUM_EN
        chk({tag, "_cksum"}, bus.cksum, 0);
`endif
    endtask

    task automatic start_op(input logic m);
        done_cnt  = 0;
        busy_cnt  = 0;
        model_cks = '0;
        bus.mode  = m;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.mode  = 1'b0;
    endtask

    // kind: 0 = fixed base+k, 1 = random words
    task automatic drive_load(input int nwords, input logic [DATA_W-1:0] base,
                              input bit rnd, input bit gaps);
        logic [DATA_W-1:0] w;
        for (int k = 1; k <= nwords; k++) begin
            while (gaps && $urandom_range(0, 2) == 0) begin
                bus.load_valid = 1'b0;
                bus.load_data  = DATA_W'($urandom);
                tick();
            end
            w = rnd ? DATA_W'($urandom) : base + DATA_W'(k);
            bus.load_valid = 1'b1;
            bus.load_data  = w;
            exp_wr_q.push_back({ADDR_W'(k), w});
            ref_regs[k] = w;
            model_cks   = model_cks ^ w;
            tick();
        end
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
    endtask

    task automatic expect_dump();
        for (int i = 0; i < NUM_REGS; i++) begin
            exp_dump_q.push_back({ADDR_W'(i), ref_regs[i]});
            model_cks = model_cks ^ ref_regs[i];
        end
    endtask

    task automatic wait_done(input string tag, input bit poke_busy, input bit poke_done);
        bit seen;
        seen = 1'b0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            bus.start = poke_busy && (cyc == 5 || cyc == 20);
            bus.mode  = 1'($urandom_range(0, 1));
            tick();
        end
        bus.start = 1'b0;
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got no done within 1000 cycles, expected a done pulse", tag);
        end else begin
`ifdef REGFILE_SCAN_CKSUM_EN
            chk({tag, "_cksum"}, bus.cksum, model_cks);
`endif
            bus.start = poke_done;
            bus.mode  = 1'b1;
            tick();
            bus.start = 1'b0;
            bus.mode  = 1'b0;
            chk({tag, "_idle_after_done"}, bus.busy, 0);
            tick();
            chk({tag, "_still_idle"}, bus.busy, 0);
            chk({tag, "_done_count"}, done_cnt, 1);
        end
        chk({tag, "_dump_q_empty"}, exp_dump_q.size(), 0);
        chk({tag, "_wr_q_empty"}, exp_wr_q.size(), 0);
    endtask

    task automatic do_dump(input string tag, input int rmode, input bit poke);
        ready_mode = rmode;
        tick();
        start_op(1'b0);
        expect_dump();
        wait_done(tag, poke, poke);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.mode       = 1'b0;
        bus.load_data  = '0;
        bus.load_valid = 1'b0;
        rf_clear       = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) ref_regs[i] = '0;
        model_cks = '0;
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk_reset_outputs("init");
        rf_clear = 1'b0;
        rst = 1'b1;
        tick();

        // Preload through LOAD, then a full dump with ready tied high
        start_op(1'b1);
        chk("load_ready_in_load", bus.load_ready, 1);
        drive_load(31, 32'hA000_0000, 1'b0, 1'b0);
        wait_done("preload", 1'b0, 1'b0);
        do_dump("dump_tied", 0, 1'b0);
        // 32 words x (DUMP_RD + DUMP_HOLD) plus the DONE cycle
        chk("dump_tied_busy_cycles", busy_cnt, 65);

        // Back-pressured dump with stray starts during busy and during DONE
        do_dump("dump_1of3", 1, 1'b1);

        // Load with gaps, then read it back
        start_op(1'b1);
        drive_load(31, 32'h1111_0000, 1'b0, 1'b1);
        wait_done("load_gaps", 1'b0, 1'b1);
        do_dump("dump_after_load", 2, 1'b0);

        // Reset after the 10th accepted load word while load_valid stays high
        start_op(1'b1);
        drive_load(10, 32'h5555_0000, 1'b0, 1'b0);
        bus.load_valid = 1'b1;
        bus.load_data  = 32'h5555_000B;
        rst = 1'b0;
        tick();
        chk_reset_outputs("midload_rst");
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        rst = 1'b1;
        tick();
        do_dump("dump_after_rst", 0, 1'b0);

        // Randomized load/dump rounds
        for (int r = 0; r < 3; r++) begin
            start_op(1'b1);
            drive_load(31, '0, 1'b1, 1'b1);
            wait_done("rand_load", 1'b1, 1'b0);
            do_dump("rand_dump", 2, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
